// File: rtl/k423_bpu_pkg.sv
// Shared types and field layout for the IF-stage set-associative BTB.
// Entry widths follow BTB_ADDR_W / BTB_TAG_W; the BTB's ADDR_W and TAG_W must match them.
package k423_bpu_pkg;

    localparam int BTB_ADDR_W  = 32;
    localparam int BTB_SETS    = 16;
    localparam int BTB_WAYS    = 2;
    localparam int BTB_TAG_W   = 8;
    localparam int BTB_IDX_W   = $clog2(BTB_SETS);
    localparam int BTB_IDX_LSB = 2;
    localparam int BTB_TAG_LSB = BTB_IDX_LSB + BTB_IDX_W;

    typedef struct packed {
        logic                  vld;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_ADDR_W-1:0] bta;
    } btb_entry_t;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_FLUSH = 1'b1
    } btb_fsm_e;

endpackage

// File: rtl/k423_if_bpu_btb_way_sel.sv
// Combinational way selection for one BTB set: tag hit (lowest way wins) and
// allocation victim (lowest invalid way, else the round-robin way).
module k423_if_bpu_btb_way_sel
    import k423_bpu_pkg::*;
#(
    parameter  int WAYS  = BTB_WAYS,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  btb_entry_t [WAYS-1:0] set_i,
    input  logic [BTB_TAG_W-1:0]  tag_i,
    input  logic [WAY_W-1:0]      rr_i,
    output logic                  hit_o,
    output logic [WAY_W-1:0]      hit_way_o,
    output logic [WAY_W-1:0]      alloc_way_o
);

    always_comb begin
        hit_o       = 1'b0;
        hit_way_o   = '0;
        alloc_way_o = rr_i;
        // Walk from the top way down so the lowest matching/free way is the last writer.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_i[w].vld && (set_i[w].tag == tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(w);
            end
            if (!set_i[w].vld) begin
                alloc_way_o = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/k423_if_bpu_btb_sa.sv
// Set-associative IF-stage BTB with round-robin replacement and a set-by-set flush FSM.
// Define K423_BTB_PRD_REG_EN to register the prediction outputs (one-cycle latency).
module k423_if_bpu_btb_sa
    import k423_bpu_pkg::*;
#(
    parameter int ADDR_W = BTB_ADDR_W,
    parameter int SETS   = BTB_SETS,
    parameter int WAYS   = BTB_WAYS,
    parameter int TAG_W  = BTB_TAG_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    output logic              flush_busy_o,
    input  logic [ADDR_W-1:0] prd_src_pc_i,
    output logic              prd_vld_o,
    output logic [ADDR_W-1:0] prd_tgt_pc_o,
    input  logic              upd_vld_i,
    input  logic              upd_tkn_i,
    input  logic [ADDR_W-1:0] upd_src_pc_i,
    input  logic [ADDR_W-1:0] upd_tgt_pc_i
);

    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = $clog2(WAYS);
    localparam int TAG_LSB = BTB_IDX_LSB + IDX_W;

    btb_entry_t [WAYS-1:0] mem_q [SETS];
    btb_entry_t [WAYS-1:0] mem_d [SETS];
    logic [WAY_W-1:0]      rr_q  [SETS];
    logic [WAY_W-1:0]      rr_d  [SETS];
    btb_fsm_e              state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0] prd_idx, upd_idx;
    logic [TAG_W-1:0] prd_tag, upd_tag;
    logic             prd_hit, upd_hit, flushing, upd_en;
    logic [WAY_W-1:0] prd_way, upd_hit_way, upd_alloc_way;
    logic             prd_vld_c;
    logic [ADDR_W-1:0] prd_tgt_c;

    assign prd_idx = prd_src_pc_i[BTB_IDX_LSB +: IDX_W];
    assign prd_tag = prd_src_pc_i[TAG_LSB +: TAG_W];
    assign upd_idx = upd_src_pc_i[BTB_IDX_LSB +: IDX_W];
    assign upd_tag = upd_src_pc_i[TAG_LSB +: TAG_W];

    assign flushing     = (state_q == BTB_FLUSH);
    assign flush_busy_o = flushing;
    // A flush request in IDLE takes priority over a simultaneous update.
    assign upd_en       = upd_vld_i && !flushing && !flush_i;

    k423_if_bpu_btb_way_sel #(.WAYS(WAYS)) u_prd_sel (
        .set_i       (mem_q[prd_idx]),
        .tag_i       (prd_tag),
        .rr_i        (rr_q[prd_idx]),
        .hit_o       (prd_hit),
        .hit_way_o   (prd_way),
        .alloc_way_o ()
    );

    k423_if_bpu_btb_way_sel #(.WAYS(WAYS)) u_upd_sel (
        .set_i       (mem_q[upd_idx]),
        .tag_i       (upd_tag),
        .rr_i        (rr_q[upd_idx]),
        .hit_o       (upd_hit),
        .hit_way_o   (upd_hit_way),
        .alloc_way_o (upd_alloc_way)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        rr_d    = rr_q;

        case (state_q)
            BTB_IDLE: begin
                if (flush_i) begin
                    state_d = BTB_FLUSH;
                    cnt_d   = '0;
                end
            end
            BTB_FLUSH: begin
                for (int w = 0; w < WAYS; w++) begin
                    mem_d[cnt_q][w].vld = 1'b0;
                end
                rr_d[cnt_q] = '0;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = BTB_IDLE;
                end
            end
            default: state_d = BTB_IDLE;
        endcase

        if (upd_en) begin
            if (upd_tkn_i && upd_hit) begin
                mem_d[upd_idx][upd_hit_way].bta = upd_tgt_pc_i;
            end else if (upd_tkn_i) begin
                mem_d[upd_idx][upd_alloc_way] = '{vld: 1'b1, tag: upd_tag, bta: upd_tgt_pc_i};
                // Victim pointer only advances when a valid entry was displaced.
                if (&{mem_q[upd_idx][WAYS-1:0]} == 1'b0) begin
                    rr_d[upd_idx] = rr_q[upd_idx];
                end
                if (mem_full(mem_q[upd_idx])) begin
                    rr_d[upd_idx] = rr_q[upd_idx] + 1'b1;
                end
            end else if (upd_hit) begin
                mem_d[upd_idx][upd_hit_way].vld = 1'b0;
            end
        end
    end

    function automatic logic mem_full(input btb_entry_t [WAYS-1:0] set);
        logic full;
        full = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            full &= set[w].vld;
        end
        return full;
    endfunction

    // NOTE: the array is built from flops, so reset clears it directly; there is no RAM init path.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= BTB_IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s]  <= '0;
                mem_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            rr_q    <= rr_d;
        end
    end

    assign prd_vld_c = prd_hit && !flushing;
    assign prd_tgt_c = prd_vld_c ? mem_q[prd_idx][prd_way].bta : '0;

`ifdef K423_BTB_PRD_REG_EN
    logic              prd_vld_q, prd_vld_d;
    logic [ADDR_W-1:0] prd_tgt_q, prd_tgt_d;

    always_comb begin
        prd_vld_d = prd_vld_c;
        prd_tgt_d = prd_tgt_c;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prd_vld_q <= 1'b0;
            prd_tgt_q <= '0;
        end else begin
            prd_vld_q <= prd_vld_d;
            prd_tgt_q <= prd_tgt_d;
        end
    end

    assign prd_vld_o    = prd_vld_q && !flushing;
    assign prd_tgt_pc_o = flushing ? '0 : prd_tgt_q;
`else
    assign prd_vld_o    = prd_vld_c;
    assign prd_tgt_pc_o = prd_tgt_c;
`endif

endmodule
